// File: rtl/read_logic_fwft_if.sv
`default_nettype none
// ============================================================================
//  Module      : read_logic_fwft_if
//  Description : Read-side bundle of the async FIFO. It carries the consumer
//                handshake, the memory read port and the cross-domain pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface read_logic_fwft_if #(
    parameter int WIDTH     = 32,
    parameter int ADR_WIDTH = 3
);
    logic                   rd_en;
    logic [ADR_WIDTH:0]     wr_ptr_gray;
    logic [WIDTH-1:0]       mem_rdata;
    logic                   read;
    logic [ADR_WIDTH:0]     read_adr;
    logic [ADR_WIDTH:0]     rd_ptr_gray;
    logic                   FIFO_empty;
    logic [WIDTH-1:0]       dout;
    logic                   dout_valid;
    logic [ADR_WIDTH:0]     level;
    logic                   underflow;

    // The read controller side
    modport master (
        input  rd_en, wr_ptr_gray, mem_rdata,
        output read, read_adr, rd_ptr_gray, FIFO_empty, dout, dout_valid,
               level, underflow
    );

    // Consumer, memory and write-domain side
    modport slave (
        output rd_en, wr_ptr_gray, mem_rdata,
        input  read, read_adr, rd_ptr_gray, FIFO_empty, dout, dout_valid,
               level, underflow
    );
endinterface
`default_nettype wire

// File: rtl/read_logic_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : read_logic_fwft
//  Description : Read-domain controller of an async FIFO. It presents data
//                first-word-fall-through from an output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_logic_fwft #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int ADR_WIDTH = $clog2(DEPTH)
) (
    input  wire logic              clk_r,
    input  wire logic              reset,
    read_logic_fwft_if.master      bus
);
    localparam int                 c_PTR_W   = ADR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [c_PTR_W-1:0] r_wq1;
    logic [c_PTR_W-1:0] r_wq2;
    logic [c_PTR_W-1:0] r_read_adr;
    logic [c_PTR_W-1:0] r_rd_ptr_gray;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_underflow;

    logic [c_PTR_W-1:0] w_wr_bin;
    logic [c_PTR_W-1:0] w_read_adr_nxt;
    logic [c_PTR_W-1:0] w_level;
    logic               w_empty;
    logic               w_pop;
    logic               w_read;

    function automatic logic [c_PTR_W-1:0] gray2bin(input logic [c_PTR_W-1:0] g);
        logic [c_PTR_W-1:0] b;
        b[c_PTR_W-1] = g[c_PTR_W-1];
        for (int i = c_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [c_PTR_W-1:0] bin2gray(input logic [c_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Empty and level are derived only from the synchronised write pointer.
    // They can lag a write by the synchroniser delay, but they never run ahead of it.
    always_comb begin
        w_wr_bin       = gray2bin(r_wq2);
        w_empty        = (r_rd_ptr_gray == r_wq2);
        w_level        = w_wr_bin - r_read_adr;
        w_pop          = bus.rd_en && r_dout_valid;
        w_read         = !w_empty && (!r_dout_valid || w_pop);
        w_read_adr_nxt = r_read_adr + c_PTR_ONE;
    end

    always_ff @(posedge clk_r or negedge reset) begin
        if (!reset) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= bus.wr_ptr_gray;
            r_wq2 <= r_wq1;
        end
    end

    // A refill on the same edge as a pop keeps dout_valid high.
    // This sustains one word per cycle.
    always_ff @(posedge clk_r or negedge reset) begin
        if (!reset) begin
            r_read_adr    <= '0;
            r_rd_ptr_gray <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_underflow <= bus.rd_en && !r_dout_valid;
            if (w_read) begin
                r_dout        <= bus.mem_rdata;
                r_dout_valid  <= 1'b1;
                r_read_adr    <= w_read_adr_nxt;
                r_rd_ptr_gray <= bin2gray(w_read_adr_nxt);
            end else if (w_pop) begin
                r_dout_valid  <= 1'b0;
            end
        end
    end

    assign bus.read        = w_read;
    assign bus.read_adr    = r_read_adr;
    assign bus.rd_ptr_gray = r_rd_ptr_gray;
    assign bus.FIFO_empty  = w_empty;
    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.level       = w_level;
    assign bus.underflow   = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_read_logic_fwft.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_read_logic_fwft
//  Description : Randomised bench for read_logic_fwft against a count/queue model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_logic_fwft;
    localparam int c_WIDTH = 32;
    localparam int c_DEPTH = 8;
    localparam int c_AW    = 3;
    localparam int c_PMOD  = 2 * c_DEPTH;

    logic clk_r = 1'b0;
    logic reset = 1'b0;

    read_logic_fwft_if #(.WIDTH(c_WIDTH), .ADR_WIDTH(c_AW)) bus ();

    read_logic_fwft #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) dut (
        .clk_r (clk_r),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_r = ~clk_r;

    logic [c_WIDTH-1:0] mem [c_DEPTH];
    assign bus.mem_rdata = mem[bus.read_adr[c_AW-1:0]];

    // Model: words are counted with plain integers; hist holds every word written
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 wr_cnt, m_rd, m_wp1, m_wp2;
    bit                 m_valid, m_under;
    logic [c_WIDTH-1:0] m_dout;
    logic [c_WIDTH-1:0] hist [$];

    function automatic logic [c_AW:0] to_gray(input int v);
        logic [c_AW:0] b;
        b = (c_AW+1)'(v % c_PMOD);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_cnt  = 0;
        m_rd    = 0;
        m_wp1   = 0;
        m_wp2   = 0;
        m_valid = 0;
        m_under = 0;
        m_dout  = '0;
        hist.delete();
        bus.wr_ptr_gray = '0;
        bus.rd_en       = 1'b0;
    endtask

    task automatic push_word(input logic [c_WIDTH-1:0] d);
        if (wr_cnt - m_rd < c_DEPTH) begin
            mem[wr_cnt % c_DEPTH] = d;
            hist.push_back(d);
            wr_cnt++;
            bus.wr_ptr_gray = to_gray(wr_cnt);
        end
    endtask

    task automatic model_edge();
        int avail;
        bit pop, rd;
        avail   = m_wp2 - m_rd;
        pop     = bus.rd_en && m_valid;
        rd      = (avail > 0) && (!m_valid || pop);
        m_under = bus.rd_en && !m_valid;
        if (rd) begin
            m_dout  = hist[m_rd];
            m_rd++;
            m_valid = 1;
        end else if (pop) begin
            m_valid = 0;
        end
        m_wp2 = m_wp1;
        m_wp1 = wr_cnt;
    endtask

    task automatic compare_all();
        int avail;
        bit exp_read;
        avail    = m_wp2 - m_rd;
        exp_read = (avail > 0) && (!m_valid || bus.rd_en);
        check("read",        64'(bus.read),        64'(exp_read));
        check("read_adr",    64'(bus.read_adr),    64'(m_rd % c_PMOD));
        check("rd_ptr_gray", 64'(bus.rd_ptr_gray), 64'(to_gray(m_rd)));
        check("FIFO_empty",  64'(bus.FIFO_empty),  64'(avail == 0));
        check("level",       64'(bus.level),       64'(avail));
        check("dout_valid",  64'(bus.dout_valid),  64'(m_valid));
        check("dout",        64'(bus.dout),        64'(m_dout));
        check("underflow",   64'(bus.underflow),   64'(m_under));
    endtask

    task automatic step(input int rd_pct, input int wr_pct);
        @(posedge clk_r);
        model_edge();
        @(negedge clk_r);
        bus.rd_en = (int'($urandom_range(99)) < rd_pct);
        if (int'($urandom_range(99)) < wr_pct) push_word($urandom);
        #1 compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"}, 64'(bus.FIFO_empty),  64'(1));
        check({tag, "_valid"}, 64'(bus.dout_valid),  64'(0));
        check({tag, "_read"},  64'(bus.read),        64'(0));
        check({tag, "_adr"},   64'(bus.read_adr),    64'(0));
        check({tag, "_gray"},  64'(bus.rd_ptr_gray), 64'(0));
        check({tag, "_level"}, 64'(bus.level),       64'(0));
        check({tag, "_dout"},  64'(bus.dout),        64'(0));
        check({tag, "_uflow"}, 64'(bus.underflow),   64'(0));
    endtask

    initial begin
        for (int i = 0; i < c_DEPTH; i++) mem[i] = '0;
        model_reset();
        repeat (3) @(posedge clk_r);
        @(negedge clk_r);
        #1 check_reset_values("rst");
        reset = 1'b1;

        // One word with the consumer idle: it falls through after the third edge
        push_word(32'hA5A50001);
        repeat (3) step(0, 0);
        check("single_dout",  64'(bus.dout),        64'(32'hA5A50001));
        check("single_valid", 64'(bus.dout_valid),  64'(1));
        check("single_adr",   64'(bus.read_adr),    64'(1));
        check("single_gray",  64'(bus.rd_ptr_gray), 64'(1));
        check("single_empty", 64'(bus.FIFO_empty),  64'(1));

        // Pop the word, then pop again while empty to force underflow
        step(100, 0);
        step(100, 0);
        step(0, 0);
        check("uflow_pulse", 64'(bus.underflow), 64'(1));
        check("uflow_adr",   64'(bus.read_adr),  64'(1));
        step(0, 0);
        check("uflow_clear", 64'(bus.underflow), 64'(0));

        // Backpressure: three words arrive while the consumer stalls
        repeat (3) step(0, 100);
        repeat (4) step(0, 0);
        check("bp_level", 64'(bus.level),      64'(2));
        check("bp_valid", 64'(bus.dout_valid), 64'(1));
        check("bp_read",  64'(bus.read),       64'(0));
        step(100, 0);
        step(0, 0);
        check("bp_refill_valid", 64'(bus.dout_valid), 64'(1));
        check("bp_refill_level", 64'(bus.level),      64'(1));

        // Full-rate streaming across several pointer wraps
        repeat (6) step(100, 0);
        repeat (60) step(100, 100);
        repeat (10) step(100, 0);

        // Random traffic mixes with asynchronous resets mid-stream
        for (int ph = 0; ph < 8; ph++) begin
            automatic int rp = int'($urandom_range(100));
            automatic int wp = int'($urandom_range(100));
            repeat (80) step(rp, wp);
            if (ph % 3 == 2) begin
                #2 reset = 1'b0;
                #1 check_reset_values("midrst");
                model_reset();
                @(posedge clk_r);
                @(negedge clk_r);
                reset = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
